// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one 32-bit word at a time over
// a req/ack handshake, presents it to decode, and redirects or traps on taken
// branches. Outputs come only from registered state, so no input reaches an
// output combinationally.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [6:0]  opcode_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        fault_o,
   output logic [31:0] retired_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] instr, instr_next;
   logic        fault, fault_next;
   logic [31:0] retired, retired_next;
   logic [31:0] pc_plus4;

   // Sequential PC; wraps modulo 2^32 with no flag.
   assign pc_plus4 = pc + 32'd4;

   // Next-state and next-register logic for the fetch FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
      state_next   = state;
      pc_next      = pc;
      instr_next   = instr;
      fault_next   = fault;
      retired_next = retired;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            // Address is held at pc until memory acknowledges.
            if (imem_ack_i) begin
               instr_next = imem_rdata_i;
               state_next = VALID;
            end
         end
         VALID: begin
            // A stalled instruction is frozen; branch_taken_i is ignored until consumed.
            if (!stall_i) begin
               retired_next = retired + 32'd1;
               if (!branch_taken_i) begin
                  pc_next    = pc_plus4;
                  state_next = FETCH;
               end else if (branch_target_i[1:0] == 2'b00) begin
                  pc_next    = branch_target_i;
                  state_next = FETCH;
               end else begin
                  // Misaligned target: keep pc of the offending instruction and trap.
                  fault_next = 1'b1;
                  state_next = FAULT;
               end
            end
         end
         FAULT: begin
            // Terminal until reset; memory acks here are ignored.
            state_next = FAULT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
      if (!rst_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         instr   <= 32'h0000_0000;
         fault   <= 1'b0;
         retired <= 32'h0000_0000;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         instr   <= instr_next;
         fault   <= fault_next;
         retired <= retired_next;
      end
   end

   // Outputs decoded from registered state only.
   assign imem_req_o    = (state == FETCH);
   assign imem_addr_o   = pc;
   assign instr_valid_o = (state == VALID);
   assign instr_o       = instr;
   assign opcode_o      = instr[6:0];
   assign pc_o          = pc;
   assign pc_plus4_o    = pc_plus4;
   assign fault_o       = fault;
   assign retired_o     = retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled on
// the falling edge, memory responses are driven by hand with chosen wait counts.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [6:0]  opcode_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        fault_o;
   logic [31:0] retired_o;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ack_i      (imem_ack_i),
      .imem_rdata_i    (imem_rdata_i),
      .instr_valid_o   (instr_valid_o),
      .instr_o         (instr_o),
      .opcode_o        (opcode_o),
      .pc_o            (pc_o),
      .pc_plus4_o      (pc_plus4_o),
      .fault_o         (fault_o),
      .retired_o       (retired_o)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Entered at a falling edge in FETCH; holds ack low for 'waits' cycles,
   // then returns the word and ends at the falling edge where VALID shows.
   task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits);
      for (int i = 0; i < waits; i++) begin
         check("wait_req", 32'(imem_req_o), 32'd1);
         check("wait_addr", imem_addr_o, addr);
         check("wait_valid", 32'(instr_valid_o), 32'd0);
         @(negedge clk);
      end
      check("req", 32'(imem_req_o), 32'd1);
      check("addr", imem_addr_o, addr);
      imem_ack_i   = 1'b1;
      imem_rdata_i = word;
      @(negedge clk);
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'h0;
      check("valid", 32'(instr_valid_o), 32'd1);
      check("valid_req", 32'(imem_req_o), 32'd0);
      check("instr", instr_o, word);
      check("pc", pc_o, addr);
   endtask

   initial begin
      rst_n           = 1'b0;
      stall_i         = 1'b0;
      branch_taken_i  = 1'b0;
      branch_target_i = 32'h0;
      imem_ack_i      = 1'b0;
      imem_rdata_i    = 32'h0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_addr", imem_addr_o, 32'h0);
      check("rst_instr", instr_o, 32'h0);
      check("rst_fault", 32'(fault_o), 32'd0);
      check("rst_retired", retired_o, 32'd0);

      // Release: IDLE one cycle, then zero-wait fetch from 0.
      rst_n = 1'b1;
      @(negedge clk);
      fetch(32'h0, 32'h0050_0093, 0);
      check("opcode", 32'(opcode_o), 32'h13);
      check("pc_plus4", pc_plus4_o, 32'h4);

      // Consume, then sequential fetches with 3 wait cycles each.
      @(negedge clk);
      check("retired_1", retired_o, 32'd1);
      fetch(32'h4, 32'h0010_0113, 3);
      @(negedge clk);
      fetch(32'h8, 32'h0020_0193, 3);
      @(negedge clk);
      check("retired_3", retired_o, 32'd3);

      // Stall with a taken branch asserted: nothing moves.
      fetch(32'hC, 32'h0000_006F, 0);
      stall_i         = 1'b1;
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(instr_valid_o), 32'd1);
         check("stall_pc", pc_o, 32'hC);
         check("stall_req", 32'(imem_req_o), 32'd0);
         check("stall_retired", retired_o, 32'd3);
      end
      stall_i        = 1'b0;
      branch_taken_i = 1'b0;
      @(negedge clk);
      check("unstall_addr", imem_addr_o, 32'h10);
      check("unstall_retired", retired_o, 32'd4);

      // Aligned redirect to 0x100.
      fetch(32'h10, 32'h0F00_006F, 0);
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h100;
      @(negedge clk);
      branch_taken_i = 1'b0;
      check("redir_req", 32'(imem_req_o), 32'd1);
      check("redir_addr", imem_addr_o, 32'h100);
      fetch(32'h100, 32'h0000_0013, 0);

      // Redirect to top of address space; pc+4 wraps to 0.
      branch_taken_i  = 1'b1;
      branch_target_i = 32'hFFFF_FFFC;
      @(negedge clk);
      branch_taken_i = 1'b0;
      fetch(32'hFFFF_FFFC, 32'h0000_0013, 0);
      check("wrap_plus4", pc_plus4_o, 32'h0);
      @(negedge clk);
      check("wrap_addr", imem_addr_o, 32'h0);
      check("wrap_retired", retired_o, 32'd7);

      // Reset mid-fetch with a late ack: must not be captured.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'hDEAD_BEEF;
      check("late_req", 32'(imem_req_o), 32'd0);
      check("late_valid", 32'(instr_valid_o), 32'd0);
      @(negedge clk);
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'h0;
      check("late_valid2", 32'(instr_valid_o), 32'd0);
      check("late_instr", instr_o, 32'h0);
      check("late_retired", retired_o, 32'd0);

      // Misaligned redirect traps; fault is sticky and acks are ignored.
      fetch(32'h0, 32'h0020_006F, 0);
      branch_taken_i  = 1'b1;
      branch_target_i = 32'h102;
      @(negedge clk);
      branch_taken_i = 1'b0;
      check("fault_retired", retired_o, 32'd1);
      check("fault_pc", pc_o, 32'h0);
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'h1234_5678;
      for (int i = 0; i < 20; i++) begin
         check("fault", 32'(fault_o), 32'd1);
         check("fault_valid", 32'(instr_valid_o), 32'd0);
         check("fault_req", 32'(imem_req_o), 32'd0);
         @(negedge clk);
      end
      check("fault_instr", instr_o, 32'h0020_006F);
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'h0;

      // One reset edge clears the trap and refetches RESET_PC.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("clr_fault", 32'(fault_o), 32'd0);
      @(negedge clk);
      check("refetch_req", 32'(imem_req_o), 32'd1);
      check("refetch_addr", imem_addr_o, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
